// File: rtl/mem_stage_pkg.sv
// Shared types and sizes for the MEM pipeline stage: FSM state encoding,
// datapath widths and the default watchdog limit.
package mem_stage_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
    import mem_stage_pkg::*;

    logic              MemReq;
    logic              MemWe;
    logic [DATA_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemAck;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData,
        input  MemRData, MemAck
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData,
        output MemRData, MemAck
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// 8-bit watchdog counter with synchronous clear/increment; tc flags the last
// allowed cycle so the owner can abort on the same edge.
module mem_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    // High during the LIMIT-th BUSY cycle without ack, so BUSY lasts exactly LIMIT cycles.
    assign tc = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage controller: runs EX/MEM loads/stores over the req/ack bus, stalls
// upstream while busy, registers the write-back bundle. Watchdog: MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              RegWr,
    input  logic              MemToReg,
    input  logic              MemWr,
    input  logic              MemRd,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [REG_W-1:0]  Rd,
    output logic              Stall,
    mem_access_stage_if.master mem,
    output logic              WbValid,
    output logic              WbRegWr,
    output logic [DATA_W-1:0] WbData,
    output logic [REG_W-1:0]  WbRd,
    output logic              AlignErr,
    output logic              BusErr
);

    state_t            state, state_d;
    logic [DATA_W-1:0] lat_addr, lat_wdata;
    logic              lat_we, lat_reg_wr, lat_mem_to_reg;
    logic [REG_W-1:0]  lat_rd;

    logic              mem_op, aligned, busy, latch_en, stall_c;
    logic              wb_valid_d, wb_reg_wr_d, align_err_d, bus_err_d;
    logic [DATA_W-1:0] wb_data_d;
    logic [REG_W-1:0]  wb_rd_d;

    assign mem_op  = MemRd | MemWr;
    assign aligned = (ALUOut[1:0] == 2'b00);
    assign busy    = (state == BUSY);

`ifdef MEM_TIMEOUT_EN
    logic ctr_tc;

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (Clk),
        .rst   (Clr),
        .clear (latch_en),
        .inc   (busy & ~mem.MemAck),
        .tc    (ctr_tc)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        latch_en    = 1'b0;
        stall_c     = 1'b0;
        wb_valid_d  = 1'b0;
        wb_reg_wr_d = 1'b0;
        wb_data_d   = WbData;
        wb_rd_d     = WbRd;
        align_err_d = 1'b0;
        bus_err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (!mem_op) begin
                    wb_valid_d  = 1'b1;
                    wb_reg_wr_d = RegWr;
                    wb_data_d   = ALUOut;
                    wb_rd_d     = Rd;
                end else if (aligned) begin
                    stall_c  = 1'b1;
                    latch_en = 1'b1;
                    state_d  = BUSY;
                end else begin
                    wb_valid_d  = 1'b1;
                    align_err_d = 1'b1;
                    wb_data_d   = ALUOut;
                    wb_rd_d     = Rd;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (mem.MemAck) begin
                    wb_valid_d  = 1'b1;
                    wb_reg_wr_d = lat_reg_wr;
                    wb_data_d   = (!lat_we && lat_mem_to_reg) ? mem.MemRData : lat_addr;
                    wb_rd_d     = lat_rd;
                    state_d     = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (ctr_tc) begin
                    wb_valid_d = 1'b1;
                    bus_err_d  = 1'b1;
                    wb_data_d  = lat_addr;
                    wb_rd_d    = lat_rd;
                    state_d    = DONE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            lat_addr       <= '0;
            lat_wdata      <= '0;
            lat_we         <= 1'b0;
            lat_reg_wr     <= 1'b0;
            lat_mem_to_reg <= 1'b0;
            lat_rd         <= '0;
            WbValid        <= 1'b0;
            WbRegWr        <= 1'b0;
            WbData         <= '0;
            WbRd           <= '0;
            AlignErr       <= 1'b0;
            BusErr         <= 1'b0;
        end else begin
            if (latch_en) begin
                lat_addr       <= ALUOut;
                lat_wdata      <= StoreData;
                lat_we         <= MemWr;
                // A combined read+write is executed as a store, which never writes a register.
                lat_reg_wr     <= RegWr & ~(MemRd & MemWr);
                lat_mem_to_reg <= MemToReg;
                lat_rd         <= Rd;
            end
            WbValid  <= wb_valid_d;
            WbRegWr  <= wb_reg_wr_d;
            WbData   <= wb_data_d;
            WbRd     <= wb_rd_d;
            AlignErr <= align_err_d;
            BusErr   <= bus_err_d;
        end
    end

    // Stall is gated by Clr so it drops with reset even while a memory op is still presented.
    assign Stall        = stall_c & ~Clr;
    assign mem.MemReq   = busy;
    assign mem.MemWe    = busy & lat_we;
    assign mem.MemAddr  = busy ? lat_addr  : '0;
    assign mem.MemWData = busy ? lat_wdata : '0;

endmodule
